// File: rtl/alu_op_sequencer.sv
// Multicycle control FSM that time-shares one ALU across fetch, decode and execute
// for a MIPS-subset datapath. Optional overflow exception guarded by OVERFLOW_EXC_EN.
module alu_op_sequencer #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter logic [31:0] EXC_VECTOR  = 32'h000000FE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    output logic [1:0] ALU1Selector,
    output logic [1:0] ALU2Selector,
    output logic [2:0] ALUOp,
    output logic       PCWrite,
    output logic [1:0] PCSource,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       ALUOutWrite,
    output logic       EPCWrite,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        RESET    = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        WB_R     = 4'd4,
        EXEC_I   = 4'd5,
        WB_I     = 4'd6,
        MEM_ADDR = 4'd7,
        MEM_RD   = 4'd8,
        WB_MEM   = 4'd9,
        MEM_WR   = 4'd10,
        BRANCH   = 4'd11,
`ifdef OVERFLOW_EXC_EN
        JUMP     = 4'd12,
        EXC      = 4'd13
`else
        JUMP     = 4'd12
`endif
    } state_t;

    localparam logic [3:0] LAST_WAIT = 4'(MEM_LATENCY - 1);
    localparam logic [2:0] OP_ADD    = 3'b001;
    localparam logic [2:0] OP_SUB    = 3'b010;
    localparam logic [2:0] OP_AND    = 3'b011;

    state_t     state;
    state_t     nextState;
    logic [3:0] waitCnt;
    logic [2:0] rOp;
    logic [2:0] decodedOp;
    logic       rTypeOk;
    logic       memState;
    logic       memDone;

    assign memState  = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    assign memDone   = memState && (waitCnt == LAST_WAIT);
    assign state_dbg = state;

    // The R-type ALU op is latched at dispatch so EXEC_R stays a pure state decode.
    always_comb begin
        rTypeOk   = 1'b1;
        decodedOp = OP_ADD;
        case (funct)
            6'h20:   decodedOp = OP_ADD;
            6'h22:   decodedOp = OP_SUB;
            6'h24:   decodedOp = OP_AND;
            default: rTypeOk = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RESET;
            waitCnt <= 4'd0;
            rOp     <= 3'b000;
        end else begin
            state <= nextState;
            if (memState && !memDone) begin
                waitCnt <= waitCnt + 4'd1;
            end else begin
                waitCnt <= 4'd0;
            end
            if (state == DECODE) begin
                rOp <= decodedOp;
            end
        end
    end

    always_comb begin
        nextState    = state;
        ALU1Selector = 2'b00;
        ALU2Selector = 2'b00;
        ALUOp        = 3'b000;
        PCWrite      = 1'b0;
        PCSource     = 2'b00;
        IRWrite      = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IorD         = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        MemToReg     = 1'b0;
        ALUOutWrite  = 1'b0;
`ifdef OVERFLOW_EXC_EN
        EPCWrite     = 1'b0;
`endif
        case (state)
            RESET: begin
                nextState = FETCH;
            end
            // The PC+4 increment shares the last memory cycle of the fetch.
            FETCH: begin
                MemRead = 1'b1;
                if (memDone) begin
                    IRWrite      = 1'b1;
                    ALU2Selector = 2'b01;
                    ALUOp        = OP_ADD;
                    PCWrite      = 1'b1;
                    nextState    = DECODE;
                end
            end
            DECODE: begin
                ALU2Selector = 2'b11;
                ALUOp        = OP_ADD;
                ALUOutWrite  = 1'b1;
                case (opcode)
                    6'h00:        nextState = rTypeOk ? EXEC_R : FETCH;
                    6'h08:        nextState = EXEC_I;
                    6'h23, 6'h2B: nextState = MEM_ADDR;
                    6'h04:        nextState = BRANCH;
                    6'h02:        nextState = JUMP;
                    default:      nextState = FETCH;
                endcase
            end
            EXEC_R: begin
                ALU1Selector = 2'b01;
                ALUOp        = rOp;
                ALUOutWrite  = 1'b1;
`ifdef OVERFLOW_EXC_EN
                nextState    = (alu_overflow && (rOp != OP_AND)) ? EXC : WB_R;
`else
                nextState    = WB_R;
`endif
            end
            WB_R: begin
                RegDst    = 1'b1;
                RegWrite  = 1'b1;
                nextState = FETCH;
            end
            EXEC_I: begin
                ALU1Selector = 2'b01;
                ALU2Selector = 2'b10;
                ALUOp        = OP_ADD;
                ALUOutWrite  = 1'b1;
`ifdef OVERFLOW_EXC_EN
                nextState    = alu_overflow ? EXC : WB_I;
`else
                nextState    = WB_I;
`endif
            end
            WB_I: begin
                RegWrite  = 1'b1;
                nextState = FETCH;
            end
            MEM_ADDR: begin
                ALU1Selector = 2'b01;
                ALU2Selector = 2'b10;
                ALUOp        = OP_ADD;
                ALUOutWrite  = 1'b1;
                nextState    = (opcode == 6'h2B) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (memDone) begin
                    nextState = WB_MEM;
                end
            end
            WB_MEM: begin
                MemToReg  = 1'b1;
                RegWrite  = 1'b1;
                nextState = FETCH;
            end
            MEM_WR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (memDone) begin
                    nextState = FETCH;
                end
            end
            // The only input-to-output path: the branch commits on the live zero flag.
            BRANCH: begin
                ALU1Selector = 2'b01;
                ALUOp        = OP_SUB;
                PCSource     = 2'b01;
                PCWrite      = alu_zero;
                nextState    = FETCH;
            end
            JUMP: begin
                PCSource  = 2'b10;
                PCWrite   = 1'b1;
                nextState = FETCH;
            end
`ifdef OVERFLOW_EXC_EN
            EXC: begin
                ALU2Selector = 2'b01;
                ALUOp        = OP_SUB;
                EPCWrite     = 1'b1;
                PCSource     = 2'b11;
                PCWrite      = 1'b1;
                nextState    = FETCH;
            end
`endif
            default: begin
                nextState = RESET;
            end
        endcase
    end

`ifndef OVERFLOW_EXC_EN
    assign EPCWrite = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance at MEM_LATENCY=2 and one at 3,
// sharing stimulus; the checked instance is picked per test.
module tb_alu_op_sequencer;

    typedef struct packed {
        logic [1:0] alu1Sel;
        logic [1:0] alu2Sel;
        logic [2:0] aluOp;
        logic       pcWrite;
        logic [1:0] pcSource;
        logic       irWrite;
        logic       memRead;
        logic       memWrite;
        logic       iorD;
        logic       regWrite;
        logic       regDst;
        logic       memToReg;
        logic       aluOutWrite;
        logic       epcWrite;
        logic [3:0] state;
    } obs_t;

    localparam logic [3:0] S_RESET  = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_EXEC_R = 4'd3;
    localparam logic [3:0] S_WB_R   = 4'd4;
    localparam logic [3:0] S_EXEC_I = 4'd5;
    localparam logic [3:0] S_WB_I   = 4'd6;
    localparam logic [3:0] S_WB_MEM = 4'd9;
    localparam logic [3:0] S_MEM_WR = 4'd10;
    localparam logic [3:0] S_BRANCH = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;
    localparam logic [3:0] S_EXC    = 4'd13;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       aluZero;
    logic       aluOverflow;
    logic       useL3;
    obs_t       obs2;
    obs_t       obs3;
    obs_t       obs;
    int         assertCount = 0;
    int         failCount   = 0;
    int         fetchCnt;
    int         rdCnt;
    int         wbCnt;
    int         regWriteCnt;
    int         memWriteCnt;
    logic [5:0] fnTab [3] = '{6'h20, 6'h22, 6'h24};
    logic [2:0] opTab [3] = '{3'b001, 3'b010, 3'b011};

    always #5 clk = ~clk;

    alu_op_sequencer #(.MEM_LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .alu_zero(aluZero), .alu_overflow(aluOverflow),
        .ALU1Selector(obs2.alu1Sel), .ALU2Selector(obs2.alu2Sel), .ALUOp(obs2.aluOp),
        .PCWrite(obs2.pcWrite), .PCSource(obs2.pcSource), .IRWrite(obs2.irWrite),
        .MemRead(obs2.memRead), .MemWrite(obs2.memWrite), .IorD(obs2.iorD),
        .RegWrite(obs2.regWrite), .RegDst(obs2.regDst), .MemToReg(obs2.memToReg),
        .ALUOutWrite(obs2.aluOutWrite), .EPCWrite(obs2.epcWrite), .state_dbg(obs2.state)
    );

    alu_op_sequencer #(.MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .alu_zero(aluZero), .alu_overflow(aluOverflow),
        .ALU1Selector(obs3.alu1Sel), .ALU2Selector(obs3.alu2Sel), .ALUOp(obs3.aluOp),
        .PCWrite(obs3.pcWrite), .PCSource(obs3.pcSource), .IRWrite(obs3.irWrite),
        .MemRead(obs3.memRead), .MemWrite(obs3.memWrite), .IorD(obs3.iorD),
        .RegWrite(obs3.regWrite), .RegDst(obs3.regDst), .MemToReg(obs3.memToReg),
        .ALUOutWrite(obs3.aluOutWrite), .EPCWrite(obs3.epcWrite), .state_dbg(obs3.state)
    );

    always_comb begin
        obs = useL3 ? obs3 : obs2;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Resets both instances and leaves them in the first FETCH cycle.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                 input logic zero, input logic ovf, input logic pickL3);
        useL3       = pickL3;
        opcode      = op;
        funct       = fn;
        aluZero     = zero;
        aluOverflow = ovf;
        reset       = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset       = 1'b0;
        useL3       = 1'b0;
        opcode      = 6'h00;
        funct       = 6'h20;
        aluZero     = 1'b0;
        aluOverflow = 1'b0;

        // Reset held for three edges, then released between edges.
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("resetOutputs", 32'(obs), 32'd0);
        end
        reset = 1'b1;
        checkOutput("releaseState", 32'(obs.state), 32'(S_RESET));
        tick();
        checkOutput("fetchState", 32'(obs.state), 32'(S_FETCH));
        checkOutput("fetchMemRead", 32'({obs.memRead, obs.iorD}), 32'b10);
        checkOutput("fetchC1PCWrite", 32'(obs.pcWrite), 32'd0);

        // add with L=2, continuing from the fetch above.
        tick();
        checkOutput("addC2PcInc",
                    32'({obs.pcWrite, obs.irWrite, obs.alu1Sel, obs.alu2Sel, obs.aluOp}),
                    32'({1'b1, 1'b1, 2'b00, 2'b01, 3'b001}));
        tick();
        checkOutput("addDecode",
                    32'({obs.state, obs.alu2Sel, obs.aluOutWrite}),
                    32'({S_DECODE, 2'b11, 1'b1}));
        tick();
        checkOutput("addExecR",
                    32'({obs.state, obs.alu1Sel, obs.alu2Sel, obs.aluOp}),
                    32'({S_EXEC_R, 2'b01, 2'b00, 3'b001}));
        tick();
        checkOutput("addWbR",
                    32'({obs.state, obs.regWrite, obs.regDst, obs.memToReg}),
                    32'({S_WB_R, 1'b1, 1'b1, 1'b0}));
        tick();
        checkOutput("addBackToFetch", 32'(obs.state), 32'(S_FETCH));

        // R-type ALU op selection by funct.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(6'h00, fnTab[i], 1'b0, 1'b0, 1'b0);
            tick();
            tick();
            tick();
            checkOutput("rTypeAluOp", 32'({obs.state, obs.aluOp}), 32'({S_EXEC_R, opTab[i]}));
        end

        // lw with L=3: nine cycles from first fetch to the writeback.
        applyStimulus(6'h23, 6'h00, 1'b0, 1'b0, 1'b1);
        fetchCnt    = 0;
        rdCnt       = 0;
        wbCnt       = 0;
        regWriteCnt = 0;
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) tick();
            if (obs.memRead && !obs.iorD) fetchCnt++;
            if (obs.memRead && obs.iorD) rdCnt++;
            if (obs.memToReg && obs.regWrite) wbCnt++;
            if (obs.regWrite) regWriteCnt++;
            if (c == 9) checkOutput("lwC9State", 32'(obs.state), 32'(S_WB_MEM));
        end
        checkOutput("lwFetchCycles", 32'(fetchCnt), 32'd3);
        checkOutput("lwMemRdCycles", 32'(rdCnt), 32'd3);
        checkOutput("lwMdrWriteback", 32'(wbCnt), 32'd1);
        checkOutput("lwRegWriteOnce", 32'(regWriteCnt), 32'd1);
        tick();
        checkOutput("lwBackToFetch", 32'(obs.state), 32'(S_FETCH));

        // beq taken, then the live zero flag path, then not taken.
        applyStimulus(6'h04, 6'h00, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("beqTaken",
                    32'({obs.state, obs.pcWrite, obs.pcSource, obs.aluOp, obs.alu1Sel}),
                    32'({S_BRANCH, 1'b1, 2'b01, 3'b010, 2'b01}));
        aluZero = 1'b0;
        #1;
        checkOutput("beqZeroComb", 32'(obs.pcWrite), 32'd0);
        tick();
        checkOutput("beqTakenReturn", 32'(obs.state), 32'(S_FETCH));
        applyStimulus(6'h04, 6'h00, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("beqNotTaken",
                    32'({obs.state, obs.pcWrite, obs.pcSource}),
                    32'({S_BRANCH, 1'b0, 2'b01}));
        tick();
        checkOutput("beqNotTakenReturn", 32'(obs.state), 32'(S_FETCH));

        // j
        applyStimulus(6'h02, 6'h00, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("jump",
                    32'({obs.state, obs.pcWrite, obs.pcSource}),
                    32'({S_JUMP, 1'b1, 2'b10}));
        tick();
        checkOutput("jumpReturn", 32'(obs.state), 32'(S_FETCH));

        // Undefined opcode and undefined funct both fall straight back to fetch.
        applyStimulus(6'h3F, 6'h00, 1'b0, 1'b0, 1'b0);
        regWriteCnt = 0;
        memWriteCnt = 0;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) tick();
            if (obs.regWrite) regWriteCnt++;
            if (obs.memWrite) memWriteCnt++;
        end
        tick();
        checkOutput("undefOpFetch", 32'(obs.state), 32'(S_FETCH));
        checkOutput("undefOpNoStrobes", 32'(regWriteCnt + memWriteCnt), 32'd0);
        applyStimulus(6'h00, 6'h25, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("undefFunctFetch", 32'(obs.state), 32'(S_FETCH));

        // addi with overflow asserted.
        applyStimulus(6'h08, 6'h00, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("addiExecI",
                    32'({obs.state, obs.alu1Sel, obs.alu2Sel, obs.aluOp}),
                    32'({S_EXEC_I, 2'b01, 2'b10, 3'b001}));
        tick();
`ifdef OVERFLOW_EXC_EN
        checkOutput("addiOvfExc",
                    32'({obs.state, obs.epcWrite, obs.pcSource, obs.pcWrite, obs.alu2Sel,
                         obs.aluOp, obs.regWrite}),
                    32'({S_EXC, 1'b1, 2'b11, 1'b1, 2'b01, 3'b010, 1'b0}));
`else
        checkOutput("addiOvfIgnored",
                    32'({obs.state, obs.regWrite, obs.regDst, obs.memToReg, obs.epcWrite}),
                    32'({S_WB_I, 1'b1, 1'b0, 1'b0, 1'b0}));
`endif
        tick();
        checkOutput("addiReturn", 32'(obs.state), 32'(S_FETCH));

        // sw with L=3, reset dropped mid-write: strobe must fall before the next edge.
        applyStimulus(6'h2B, 6'h00, 1'b0, 1'b0, 1'b1);
        for (int c = 2; c <= 6; c++) tick();
        checkOutput("swMemWr",
                    32'({obs.state, obs.memWrite, obs.iorD}),
                    32'({S_MEM_WR, 1'b1, 1'b1}));
        #2;
        reset = 1'b0;
        #1;
        checkOutput("asyncResetStrobes", 32'(obs), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        checkOutput("postResetFetch", 32'({obs.state, obs.memRead, obs.iorD}),
                    32'({S_FETCH, 1'b1, 1'b0}));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
